// File: rtl/data_mem_pipe_pkg.sv
// Shared types and limits for the pipelined data RAM.
package data_mem_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } mem_state_t;

  localparam int unsigned RD_LAT_MAX = 2;

endpackage

// File: rtl/data_mem_pipe_if.sv
// Request/response bus between the load/store stage and the data RAM.
interface data_mem_pipe_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
);
  logic          ReqValid;
  logic          ReqReady;
  logic          ReqWrite;
  logic [AW-1:0] ReqAddr;
  logic [DW-1:0] ReqData;
  logic          ClearReq;
  logic          Busy;
  logic          RspValid;
  logic [DW-1:0] RspData;

  modport master (
    output ReqValid, ReqWrite, ReqAddr, ReqData, ClearReq,
    input  ReqReady, Busy, RspValid, RspData
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqAddr, ReqData, ClearReq,
    output ReqReady, Busy, RspValid, RspData
  );
endinterface

// File: rtl/data_mem_pipe_array.sv
// Storage array: one synchronous write port and one registered read port.
module data_mem_array #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register captures pre-write contents on the accept edge.
  always_ff @(posedge CLK) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/data_mem_pipe.sv
// Data RAM with valid/ready request port, pipelined reads and a per-word clear engine.
module data_mem_pipe
  import data_mem_pkg::*;
#(
  parameter int unsigned   DW       = 8,
  parameter int unsigned   AW       = 8,
  parameter int unsigned   RD_LAT   = 1,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic             CLK,
  input  logic             reset,
  data_mem_pipe_if.slave   bus
);
  localparam int unsigned DEPTH = 1 << AW;

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("data_mem_pipe: RD_LAT must be 1 or 2");
  end

  mem_state_t    state, state_nxt;
  logic [AW:0]   clr_cnt;
  logic          clr_last_c;
  logic          req_ready_c;
  logic          busy_c;
  logic          rd_acc_c;
  logic          mem_we_c;
  logic [AW-1:0] mem_waddr_c;
  logic [DW-1:0] mem_wdata_c;
  logic [DW-1:0] rd_data;
  logic          rd_v1;

  assign clr_last_c = (clr_cnt == (AW+1)'(DEPTH - 1));

  always_ff @(posedge CLK) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_last_c)   state_nxt = S_RUN;
      S_RUN:   if (bus.ClearReq) state_nxt = S_CLEAR;
    endcase
  end

  // ClearReq wins over a same-cycle request; the write port is shared with the clear engine.
  always_comb begin
    req_ready_c = 1'b0;
    busy_c      = 1'b0;
    rd_acc_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_waddr_c = bus.ReqAddr;
    mem_wdata_c = bus.ReqData;
    case (state)
      S_CLEAR: begin
        busy_c      = 1'b1;
        mem_we_c    = ~reset;
        mem_waddr_c = clr_cnt[AW-1:0];
        mem_wdata_c = INIT_VAL;
      end
      S_RUN: begin
        req_ready_c = ~bus.ClearReq;
        if (bus.ReqValid && !bus.ClearReq && !reset) begin
          mem_we_c = bus.ReqWrite;
          rd_acc_c = ~bus.ReqWrite;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset)                clr_cnt <= '0;
    else if (state == S_CLEAR) clr_cnt <= clr_cnt + (AW+1)'(1);
    else if (bus.ClearReq)    clr_cnt <= '0;
  end

  data_mem_array #(.DW(DW), .AW(AW)) u_array (
    .CLK   (CLK),
    .reset (reset),
    .we    (mem_we_c),
    .waddr (mem_waddr_c),
    .wdata (mem_wdata_c),
    .re    (rd_acc_c),
    .raddr (bus.ReqAddr),
    .rdata (rd_data)
  );

  // In-flight reads survive ClearReq but are flushed by reset.
  always_ff @(posedge CLK) begin
    if (reset) rd_v1 <= 1'b0;
    else       rd_v1 <= rd_acc_c;
  end

  if (RD_LAT >= 2) begin : g_lat2
    logic          rd_v2;
    logic [DW-1:0] rd_d2;

    always_ff @(posedge CLK) begin
      if (reset) begin
        rd_v2 <= 1'b0;
        rd_d2 <= '0;
      end else begin
        rd_v2 <= rd_v1;
        if (rd_v1) rd_d2 <= rd_data;
      end
    end

    assign bus.RspValid = rd_v2;
    assign bus.RspData  = rd_d2;
  end else begin : g_lat1
    assign bus.RspValid = rd_v1;
    assign bus.RspData  = rd_data;
  end

  assign bus.ReqReady = req_ready_c;
  assign bus.Busy     = busy_c;
endmodule
